// File: rtl/mcp4922_pkg.sv
// mcp4922_pkg: constants shared by the MCP4922 receiver model.
//   Command word layout (16 bits, MSB first on the wire):
//     [15] channel select (0=A, 1=B), [14] BUF, [13] GA_n, [12] SHDN_n,
//     [11:0] DAC data.
//   Also holds the idle (reset) levels of the SPI lines and the channel enum.
package mcp4922_pkg;

   localparam int unsigned WORD_BITS = 16;
   localparam int unsigned DATA_BITS = 12;
   localparam int unsigned CFG_BITS  = 3;
   localparam int unsigned ERR_BITS  = 8;

   localparam int unsigned CHAN_BIT = 15;
   localparam int unsigned BUF_BIT  = 14;
   localparam int unsigned GA_BIT   = 13;
   localparam int unsigned SHDN_BIT = 12;

   // Bit counter saturates one past a full word so over-long frames stay distinguishable.
   localparam int unsigned             CNT_BITS = 5;
   localparam logic [CNT_BITS-1:0]     CNT_FULL = CNT_BITS'(WORD_BITS);
   localparam logic [CNT_BITS-1:0]     CNT_SAT  = CNT_BITS'(WORD_BITS + 1);

   localparam logic SCLK_IDLE  = 1'b0;
   localparam logic CS_N_IDLE  = 1'b1;
   localparam logic LAT_N_IDLE = 1'b1;
   localparam logic SDAT_IDLE  = 1'b0;

   typedef enum logic {
      CHAN_A = 1'b0,
      CHAN_B = 1'b1
   } chan_e;

   // {BUF, GA_n, SHDN_n} field of a command word.
   function automatic logic [CFG_BITS-1:0] word_cfg(input logic [WORD_BITS-1:0] word);
      return {word[BUF_BIT], word[GA_BIT], word[SHDN_BIT]};
   endfunction

   function automatic logic [DATA_BITS-1:0] word_data(input logic [WORD_BITS-1:0] word);
      return word[DATA_BITS-1:0];
   endfunction

endpackage

// File: rtl/mcp4922_rx_if.sv
// mcp4922_rx_if: the four-wire DAC link between driver and MCP4922.
//   spi_sclk  serial clock
//   spi_cs_n  chip select, active low
//   spi_lat_n LDAC latch, active low
//   spi_sdat  serial data, MSB first
// Modports: master (the DAC driver), slave (the DAC / this receiver).
interface mcp4922_rx_if;

   logic spi_sclk;
   logic spi_cs_n;
   logic spi_lat_n;
   logic spi_sdat;

   modport master (
      output spi_sclk,
      output spi_cs_n,
      output spi_lat_n,
      output spi_sdat
   );

   modport slave (
      input spi_sclk,
      input spi_cs_n,
      input spi_lat_n,
      input spi_sdat
   );

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: brings one asynchronous SPI line into the clock domain.
//   Parameters: SYNC_STAGES (>= 2) synchronizer depth, RESET_LEVEL idle level.
//   Ports:
//     clock, reset_n  system clock, async active-low reset
//     din             raw pin
//     level           synchronized level, aligned with rise/fall
//     rise, fall      one-clock edge pulses
//   A pin edge shows up on level/rise/fall SYNC_STAGES+1 clocks later.
module spi_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_LEVEL = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   // level is the edge-detect flop; the pulses are registered alongside it
   // so that a consumer sees the new level in the same cycle as its edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{RESET_LEVEL}};
         level  <= RESET_LEVEL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         level  <= synced;
         rise   <= synced & ~level;
         fall   <= ~synced & level;
      end
   end

endmodule

// File: rtl/mcp4922_rx.sv
// mcp4922_rx: receiver model of one MCP4922 dual 12-bit SPI DAC.
//   Parameters: SYNC_STAGES synchronizer depth per SPI line (>= 2).
//   Optional feature: define MCP4922_RX_ERRCNT_EN to build the saturating
//   rejected-frame counter; otherwise err_count is tied to zero.
//   Ports:
//     clock, reset_n        system clock, async active-low reset
//     spi                   DAC link (slave modport)
//     in_reg_a, in_reg_b    input (holding) registers
//     dac_a, dac_b          output registers (analog pin value)
//     cfg_a, cfg_b          {BUF, GA_n, SHDN_n} of last accepted word per channel
//     word_strobe           one-clock pulse per accepted word
//     word_chan             channel of last accepted word (0=A, 1=B)
//     lat_strobe            one-clock pulse per LAT_N falling edge
//     frame_err             one-clock pulse per rejected frame
//     err_count             saturating rejected-frame count
module mcp4922_rx
   import mcp4922_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clock,
   input  logic                 reset_n,
   mcp4922_rx_if.slave          spi,
   output logic [DATA_BITS-1:0] in_reg_a,
   output logic [DATA_BITS-1:0] in_reg_b,
   output logic [DATA_BITS-1:0] dac_a,
   output logic [DATA_BITS-1:0] dac_b,
   output logic [CFG_BITS-1:0]  cfg_a,
   output logic [CFG_BITS-1:0]  cfg_b,
   output logic                 word_strobe,
   output logic                 word_chan,
   output logic                 lat_strobe,
   output logic                 frame_err,
   output logic [ERR_BITS-1:0]  err_count
);

   logic sclk_rise;
   logic cs_level;
   logic cs_rise;
   logic cs_fall;
   logic lat_level;
   logic sdat;

   logic unused_sclk_level;
   logic unused_sclk_fall;
   logic unused_lat_rise;
   logic unused_sdat_rise;
   logic unused_sdat_fall;

   logic [WORD_BITS-1:0] shift_reg;
   logic [CNT_BITS-1:0]  bit_cnt;
   chan_e                word_sel;

   // ---------------------------------------------------------------
   // Input synchronizers
   // ---------------------------------------------------------------
   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_LEVEL (SCLK_IDLE)
   ) u_sync_sclk (
      .clock   (clock),
      .reset_n (reset_n),
      .din     (spi.spi_sclk),
      .level   (unused_sclk_level),
      .rise    (sclk_rise),
      .fall    (unused_sclk_fall)
   );

   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_LEVEL (CS_N_IDLE)
   ) u_sync_cs (
      .clock   (clock),
      .reset_n (reset_n),
      .din     (spi.spi_cs_n),
      .level   (cs_level),
      .rise    (cs_rise),
      .fall    (cs_fall)
   );

   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_LEVEL (LAT_N_IDLE)
   ) u_sync_lat (
      .clock   (clock),
      .reset_n (reset_n),
      .din     (spi.spi_lat_n),
      .level   (lat_level),
      .rise    (unused_lat_rise),
      .fall    (lat_strobe)
   );

   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_LEVEL (SDAT_IDLE)
   ) u_sync_sdat (
      .clock   (clock),
      .reset_n (reset_n),
      .din     (spi.spi_sdat),
      .level   (sdat),
      .rise    (unused_sdat_rise),
      .fall    (unused_sdat_fall)
   );

   // ---------------------------------------------------------------
   // Frame shifter and bit counter
   // ---------------------------------------------------------------
   // A CS_N fall in the same clock as an SCLK rise clears and then takes
   // that first bit, so the counter lands on 1 rather than 0.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (cs_fall) begin
         if (sclk_rise) begin
            shift_reg <= {{(WORD_BITS-1){1'b0}}, sdat};
            bit_cnt   <= CNT_BITS'(1);
         end else begin
            shift_reg <= '0;
            bit_cnt   <= '0;
         end
      end else if (sclk_rise && !cs_level) begin
         shift_reg <= {shift_reg[WORD_BITS-2:0], sdat};
         if (bit_cnt != CNT_SAT) begin
            bit_cnt <= bit_cnt + CNT_BITS'(1);
         end
      end
   end

   // ---------------------------------------------------------------
   // Word acceptance on CS_N rise
   // ---------------------------------------------------------------
   always_comb begin
      word_sel = chan_e'(shift_reg[CHAN_BIT]);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         in_reg_a    <= '0;
         in_reg_b    <= '0;
         cfg_a       <= '0;
         cfg_b       <= '0;
         word_chan   <= 1'b0;
         word_strobe <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         word_strobe <= 1'b0;
         frame_err   <= 1'b0;
         if (cs_rise) begin
            if (bit_cnt == CNT_FULL) begin
               word_strobe <= 1'b1;
               word_chan   <= shift_reg[CHAN_BIT];
               case (word_sel)
                  CHAN_A: begin
                     in_reg_a <= word_data(shift_reg);
                     cfg_a    <= word_cfg(shift_reg);
                  end
                  CHAN_B: begin
                     in_reg_b <= word_data(shift_reg);
                     cfg_b    <= word_cfg(shift_reg);
                  end
                  default: ;
               endcase
            end else begin
               frame_err <= 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Level-sensitive latch transfer
   // ---------------------------------------------------------------
   // Reads in_reg_* before this clock's write lands, so a coinciding word
   // reaches the output one clock later if LAT_N stays low.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dac_a <= '0;
         dac_b <= '0;
      end else if (!lat_level) begin
         dac_a <= in_reg_a;
         dac_b <= in_reg_b;
      end
   end

   // ---------------------------------------------------------------
   // Rejected-frame counter
   // ---------------------------------------------------------------
`ifdef MCP4922_RX_ERRCNT_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_count <= '0;
      end else if (frame_err && (err_count != '1)) begin
         err_count <= err_count + ERR_BITS'(1);
      end
   end
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_mcp4922_rx.sv
// tb_mcp4922_rx: self-checking bench for mcp4922_rx.
//   Drives SPI frames, LAT pulses and stray SCLK activity (directed, then
//   randomized) and compares every DUT output on every clock against a
//   frame-level model: a frame's effect appears a fixed latency after its
//   CS_N rise, and the DAC registers follow the rule "while LAT_N is seen
//   low, dac takes the previous clock's input register".
module tb_mcp4922_rx;

   localparam int N    = 2;        // synchronizer depth
   localparam int PH   = N + 2;    // clocks per SCLK phase / setup gap
   localparam int HIST = 60000;

   logic clk;
   logic rst_n;

   mcp4922_rx_if spi ();

   logic [11:0] in_reg_a, in_reg_b, dac_a, dac_b;
   logic [2:0]  cfg_a, cfg_b;
   logic        word_strobe, word_chan, lat_strobe, frame_err;
   logic [7:0]  err_count;

   mcp4922_rx #(
      .SYNC_STAGES (N)
   ) dut (
      .clock       (clk),
      .reset_n     (rst_n),
      .spi         (spi),
      .in_reg_a    (in_reg_a),
      .in_reg_b    (in_reg_b),
      .dac_a       (dac_a),
      .dac_b       (dac_b),
      .cfg_a       (cfg_a),
      .cfg_b       (cfg_b),
      .word_strobe (word_strobe),
      .word_chan   (word_chan),
      .lat_strobe  (lat_strobe),
      .frame_err   (frame_err),
      .err_count   (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int          cyc = 0;
   int unsigned ws_seen = 0, fe_seen = 0, ls_seen = 0;
   bit          lat_hist [HIST];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          at;
      bit          accept;
      logic [15:0] word;
   } evt_t;

   evt_t        evq [$];
   logic [11:0] e_in_a = '0, e_in_b = '0, e_dac_a = '0, e_dac_b = '0;
   logic [2:0]  e_cfg_a = '0, e_cfg_b = '0;
   logic        e_chan = 1'b0, e_ws = 1'b0, e_fe = 1'b0, e_ls = 1'b0;
   logic [7:0]  e_err = '0;
   bit          err_inc = 1'b0;

   // LAT_N as the design sees it in check cycle k (pin level N+1 clocks earlier).
   function automatic bit lat_seen(input int k);
      if (k < N + 1) return 1'b1;
      return lat_hist[k - N - 1];
   endfunction

   always @(posedge clk) begin
      evt_t ev;
      lat_hist[cyc] = spi.spi_lat_n;
      cyc++;
      #1;
      if (!rst_n) begin
         e_in_a = '0; e_in_b = '0; e_dac_a = '0; e_dac_b = '0;
         e_cfg_a = '0; e_cfg_b = '0; e_chan = 1'b0;
         e_ws = 1'b0; e_fe = 1'b0; e_ls = 1'b0; e_err = '0;
         err_inc = 1'b0;
         evq.delete();
      end else begin
         if (!lat_seen(cyc - 1)) begin
            e_dac_a = e_in_a;
            e_dac_b = e_in_b;
         end
         e_ls = !lat_seen(cyc) && lat_seen(cyc - 1);
         e_ws = 1'b0;
         e_fe = 1'b0;
         if (err_inc && e_err != 8'hFF) e_err = e_err + 8'd1;
         err_inc = 1'b0;
         while (evq.size() > 0 && evq[0].at == cyc) begin
            ev = evq.pop_front();
            if (ev.accept) begin
               e_ws   = 1'b1;
               e_chan = ev.word[15];
               if (ev.word[15]) begin
                  e_in_b  = ev.word[11:0];
                  e_cfg_b = ev.word[14:12];
               end else begin
                  e_in_a  = ev.word[11:0];
                  e_cfg_a = ev.word[14:12];
               end
            end else begin
               e_fe = 1'b1;
`ifdef MCP4922_RX_ERRCNT_EN
               err_inc = 1'b1;
`endif
            end
         end
      end
      chk("in_reg_a",    32'(in_reg_a),    32'(e_in_a));
      chk("in_reg_b",    32'(in_reg_b),    32'(e_in_b));
      chk("dac_a",       32'(dac_a),       32'(e_dac_a));
      chk("dac_b",       32'(dac_b),       32'(e_dac_b));
      chk("cfg_a",       32'(cfg_a),       32'(e_cfg_a));
      chk("cfg_b",       32'(cfg_b),       32'(e_cfg_b));
      chk("word_chan",   32'(word_chan),   32'(e_chan));
      chk("word_strobe", 32'(word_strobe), 32'(e_ws));
      chk("frame_err",   32'(frame_err),   32'(e_fe));
      chk("lat_strobe",  32'(lat_strobe),  32'(e_ls));
      chk("err_count",   32'(err_count),   32'(e_err));
      if (word_strobe === 1'b1) ws_seen++;
      if (frame_err === 1'b1)   fe_seen++;
      if (lat_strobe === 1'b1)  ls_seen++;
   end

   initial begin
      #550000;
      $display("FAIL watchdog: simulation did not complete within the time budget");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clock_bit(input logic b);
      spi.spi_sdat = b;
      tick(PH);
      spi.spi_sclk = 1'b1;
      tick(PH);
      spi.spi_sclk = 1'b0;
   endtask

   // CS_N low, nbits SCLK pulses MSB first; CS_N left low.
   task automatic frame_body(input logic [31:0] value, input int nbits, input bit coincide);
      int first;
      @(negedge clk);
      if (coincide && nbits > 0) begin
         spi.spi_sdat = value[nbits-1];
         spi.spi_cs_n = 1'b0;
         spi.spi_sclk = 1'b1;
         tick(PH);
         spi.spi_sclk = 1'b0;
         first = 1;
      end else begin
         spi.spi_cs_n = 1'b0;
         first = 0;
      end
      for (int b = first; b < nbits; b++) clock_bit(value[nbits-1-b]);
      tick(PH);
   endtask

   task automatic push_frame(input logic [31:0] value, input int nbits);
      evt_t ev;
      ev.at     = cyc + N + 2;
      ev.accept = (nbits == 16);
      ev.word   = value[15:0];
      evq.push_back(ev);
   endtask

   task automatic send_frame(input logic [31:0] value, input int nbits,
                             input bit coincide, input bit lat_too);
      frame_body(value, nbits, coincide);
      spi.spi_cs_n = 1'b1;
      if (lat_too) spi.spi_lat_n = 1'b0;
      push_frame(value, nbits);
      if (lat_too) begin
         tick(PH + 1);
         spi.spi_lat_n = 1'b1;
      end
      tick(PH + 4);
   endtask

   task automatic lat_pulse(input int len);
      @(negedge clk);
      spi.spi_lat_n = 1'b0;
      tick(len);
      spi.spi_lat_n = 1'b1;
      tick(PH + 2);
   endtask

   task automatic sclk_pulses(input int n);
      @(negedge clk);
      repeat (n) begin
         spi.spi_sclk = 1'b1;
         tick(PH);
         spi.spi_sclk = 1'b0;
         tick(PH);
      end
      tick(2);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int unsigned ws0, fe0, ls0;
      int          c0;
      logic [15:0] w;
      logic [31:0] v;
      int unsigned r;
      int          n;

      rst_n = 1'b0;
      spi.spi_sclk = 1'b0;
      spi.spi_cs_n = 1'b1;
      spi.spi_lat_n = 1'b1;
      spi.spi_sdat = 1'b0;
      tick(5);
      chk("reset_in_a", 32'(in_reg_a), 32'h0);
      chk("reset_dac_b", 32'(dac_b), 32'h0);
      rst_n = 1'b1;
      tick(5);

      // single word, no latch
      ws0 = ws_seen;
      send_frame(32'h7ABC, 16, 1'b0, 1'b0);
      chk("t1_in_a", 32'(in_reg_a), 32'hABC);
      chk("t1_cfg_a", 32'(cfg_a), 32'h7);
      chk("t1_chan", 32'(word_chan), 32'h0);
      chk("t1_ws", ws_seen - ws0, 32'd1);
      chk("t1_dac_a", 32'(dac_a), 32'h000);

      // latch pulse
      ls0 = ls_seen;
      lat_pulse(4);
      chk("t2_dac_a", 32'(dac_a), 32'hABC);
      chk("t2_ls", ls_seen - ls0, 32'd1);
      chk("t2_dac_b", 32'(dac_b), 32'h000);

      // driver-style A, B, latch
      send_frame(32'h7123, 16, 1'b0, 1'b0);
      send_frame(32'hF456, 16, 1'b0, 1'b0);
      lat_pulse(4);
      chk("t3_dac_a", 32'(dac_a), 32'h123);
      chk("t3_dac_b", 32'(dac_b), 32'h456);
      chk("t3_cfg_b", 32'(cfg_b), 32'h7);

      // short and long frames are rejected
      fe0 = fe_seen;
      send_frame(32'h0000_5A5A, 15, 1'b0, 1'b0);
      send_frame(32'h0001_A5A5, 17, 1'b0, 1'b0);
      chk("t4_fe", fe_seen - fe0, 32'd2);
      chk("t4_in_a", 32'(in_reg_a), 32'h123);
      chk("t4_in_b", 32'(in_reg_b), 32'h456);
`ifdef MCP4922_RX_ERRCNT_EN
      chk("t4_err_count", 32'(err_count), 32'd2);
`else
      chk("t4_err_count", 32'(err_count), 32'd0);
`endif

      // reset in the middle of a frame
      w = 16'hF0FF;
      @(negedge clk);
      spi.spi_cs_n = 1'b0;
      tick(PH);
      for (int b = 0; b < 8; b++) clock_bit(w[15-b]);
      rst_n = 1'b0;
      tick(3);
      spi.spi_cs_n = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(PH + 4);
      chk("t5_in_a", 32'(in_reg_a), 32'h0);
      chk("t5_in_b", 32'(in_reg_b), 32'h0);
      chk("t5_dac_a", 32'(dac_a), 32'h0);
      chk("t5_dac_b", 32'(dac_b), 32'h0);
      chk("t5_cfg_b", 32'(cfg_b), 32'h0);
      chk("t5_err_count", 32'(err_count), 32'h0);
      send_frame(32'hF0FF, 16, 1'b0, 1'b0);
      chk("t5_in_b_after", 32'(in_reg_b), 32'h0FF);
      chk("t5_chan_after", 32'(word_chan), 32'h1);

      // SCLK activity with CS_N high is ignored
      ws0 = ws_seen;
      fe0 = fe_seen;
      sclk_pulses(20);
      chk("t6_ws", ws_seen - ws0, 32'd0);
      chk("t6_fe", fe_seen - fe0, 32'd0);
      chk("t6_in_b", 32'(in_reg_b), 32'h0FF);

      // word write coinciding with LAT_N low
      send_frame(32'h7AAA, 16, 1'b0, 1'b0);
      frame_body(32'h7555, 16, 1'b0);
      spi.spi_cs_n = 1'b1;
      spi.spi_lat_n = 1'b0;
      c0 = cyc;
      push_frame(32'h7555, 16);
      repeat (N + 1) @(posedge clk);
      #2;
      chk("t7_dac_before", 32'(dac_a), 32'h000);
      chk("t7_in_before", 32'(in_reg_a), 32'hAAA);
      @(posedge clk);
      #2;
      chk("t7_dac_old", 32'(dac_a), 32'hAAA);
      chk("t7_in_new", 32'(in_reg_a), 32'h555);
      @(posedge clk);
      #2;
      chk("t7_dac_new", 32'(dac_a), 32'h555);
      chk("t7_cycle", 32'(cyc - c0), 32'(N + 3));
      @(negedge clk);
      tick(2);
      spi.spi_lat_n = 1'b1;
      tick(PH + 4);

      // CS_N fall and first SCLK rise in the same clock
      send_frame(32'hB5A5, 16, 1'b1, 1'b0);
      chk("t8_in_b", 32'(in_reg_b), 32'h5A5);
      chk("t8_cfg_b", 32'(cfg_b), 32'h3);

      // randomized traffic
      for (int it = 0; it < 48; it++) begin
         r = $urandom_range(0, 9);
         v = $urandom;
         case (r)
            0, 1, 2, 3, 4: send_frame(v, 16, 1'($urandom_range(0, 1)), 1'b0);
            5: begin
               n = int'($urandom_range(0, 18));
               if (n == 16) n = 15;
               send_frame(v, n, 1'($urandom_range(0, 1)), 1'b0);
            end
            6: lat_pulse(PH + int'($urandom_range(0, 4)));
            7: sclk_pulses(int'($urandom_range(1, 6)));
            default: send_frame(v, 16, 1'($urandom_range(0, 1)), 1'b1);
         endcase
      end

      tick(20);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
